// File: rtl/keypad_emulator_if.sv
// Command channel between a key-press source and the keypad emulator.
// master: drives key_valid/key_code/abort; slave: drives key_ready/pressed/done.
interface keypad_emulator_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic       abort;
   logic       pressed;
   logic       done;

   modport master (
      output key_valid,
      output key_code,
      output abort,
      input  key_ready,
      input  pressed,
      input  done
   );

   modport slave (
      input  key_valid,
      input  key_code,
      input  abort,
      output key_ready,
      output pressed,
      output done
   );
endinterface

// File: rtl/keypad_emulator.sv
// Passive 4x4 matrix keypad: closes one contact per command with optional bounce.
// Ports: clk, rst_n, col (strobe in), fila (rows out), kif (command channel, slave).
module keypad_emulator #(
   parameter int unsigned HOLD_CYCLES   = 2_097_152,
   parameter int unsigned BOUNCE_CYCLES = 131_072,
   parameter int unsigned BOUNCE_PERIOD = 8_192,
   parameter int unsigned GAP_CYCLES    = 1_048_576
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           col,
   output logic [3:0]           fila,
   keypad_emulator_if.slave     kif
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_BOUNCE,
      HOLD,
      RELEASE_BOUNCE,
      GAP
   } state_t;

   localparam logic [31:0] H_LAST = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] B_LAST = 32'(BOUNCE_CYCLES - 1);
   localparam logic [31:0] P_LAST = 32'(BOUNCE_PERIOD - 1);
   localparam logic [31:0] G_LAST = 32'(GAP_CYCLES - 1);

   localparam logic NO_BNC = (BOUNCE_CYCLES == 0);
   localparam logic NO_GAP = (GAP_CYCLES == 0);

   // Zero-length phases are skipped entirely.
   localparam state_t AFTER_RB   = NO_GAP ? IDLE : GAP;
   localparam state_t AFTER_HOLD = NO_BNC ? AFTER_RB : RELEASE_BOUNCE;
   localparam state_t AFTER_IDLE = NO_BNC ? HOLD : PRESS_BOUNCE;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] pcnt_q, pcnt_d;
   logic        pressed_q, pressed_d;
   logic        done_q, done_d;
   logic [3:0]  code_q, code_d;
   logic        enter;
   logic        flip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pcnt_q    <= '0;
         pressed_q <= 1'b0;
         done_q    <= 1'b0;
         code_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pcnt_q    <= pcnt_d;
         pressed_q <= pressed_d;
         done_q    <= done_d;
         code_q    <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      case (state_q)
         IDLE: begin
            if (kif.key_valid) begin
               state_d = AFTER_IDLE;
               code_d  = kif.key_code;
            end
         end
         PRESS_BOUNCE: begin
            if (kif.abort)
               state_d = AFTER_HOLD;
            else if (cnt_q == B_LAST)
               state_d = HOLD;
         end
         HOLD: begin
            if (kif.abort || cnt_q == H_LAST)
               state_d = AFTER_HOLD;
         end
         RELEASE_BOUNCE: begin
            if (cnt_q == B_LAST)
               state_d = AFTER_RB;
         end
         GAP: begin
            if (cnt_q == G_LAST)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      enter = (state_d != state_q);
      flip  = (pcnt_q == P_LAST);

      cnt_d = (enter || state_q == IDLE) ? '0 : cnt_q + 32'd1;

      // Bounce half-period counter restarts on every phase entry.
      pcnt_d = '0;
      if (!enter && !flip)
         pcnt_d = pcnt_q + 32'd1;

      pressed_d = 1'b0;
      pcnt_d    = (state_d == PRESS_BOUNCE || state_d == RELEASE_BOUNCE)
                  ? pcnt_d : '0;
      case (state_d)
         HOLD:           pressed_d = 1'b1;
         PRESS_BOUNCE:   pressed_d = enter ? 1'b1 : (pressed_q ^ flip);
         RELEASE_BOUNCE: pressed_d = enter ? 1'b0 : (pressed_q ^ flip);
         default:        pressed_d = 1'b0;
      endcase

      done_d = enter && (state_d == IDLE);
   end

   // Rows follow the strobe with no latency so the scanner sees its own col.
   always_comb begin
      fila = 4'b0000;
      if (pressed_q && col[code_q[3:2]])
         fila = 4'b0001 << code_q[1:0];
   end

   assign kif.key_ready = (state_q == IDLE);
   assign kif.pressed   = pressed_q;
   assign kif.done      = done_q;

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Behavioural 4x4 matrix-keypad emulator: the passive keypad at the far end of the column-strobe / row-sense scan interface. It accepts key-press commands over a valid/ready handshake. For each command it closes one matrix contact for a programmed time, with optional contact bounce on press and release. While the contact is closed, it drives the row lines in response to whatever one-hot column strobe the scanner applies. It feeds the keypad scanner in self-test builds and in the scanner's simulation bench, standing in for the physical keypad.

## Interface
- HOLD_CYCLES, 2_097_152, cycles the contact is held solidly closed (≥1); default is 4 full scans at a 2^17-cycle column step
- BOUNCE_CYCLES, 131_072, length of the press-bounce and release-bounce windows in cycles (0 = no bounce)
- BOUNCE_PERIOD, 8_192, cycles per bounce half-period (≥1)
- GAP_CYCLES, 1_048_576, contact-open cycles after release before the next command is accepted (0 allowed)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- col  in  4  column strobe from the scanner, one-hot or zero
- fila  out  4  row sense lines to the scanner, active high
- key_valid  in  1  command valid
- key_code  in  4  key position: [3:2] = column index c, [1:0] = row index r (position 0 = col 0001, fila 0001; position 5 = col 0010, fila 0010)
- key_ready  out  1  emulator can accept a command
- abort  in  1  end the current press early
- pressed  out  1  current contact state (1 = closed)
- done  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP.
- key_ready = 1 only in IDLE.
- Accept: key_valid && key_ready at a rising clk edge. key_code is latched into code_q on that edge.
- IDLE -> PRESS_BOUNCE on accept, or -> HOLD if BOUNCE_CYCLES = 0.
- PRESS_BOUNCE -> HOLD after BOUNCE_CYCLES cycles.
- HOLD -> RELEASE_BOUNCE after HOLD_CYCLES cycles, or -> GAP if BOUNCE_CYCLES = 0.
- RELEASE_BOUNCE -> GAP after BOUNCE_CYCLES cycles, or -> IDLE if GAP_CYCLES = 0.
- GAP -> IDLE after GAP_CYCLES cycles.
- Contact (pressed), all registered:
  - IDLE and GAP: 0.
  - HOLD: 1.
  - PRESS_BOUNCE: 1 for the first BOUNCE_PERIOD cycles, then 0, alternating every BOUNCE_PERIOD cycles.
  - RELEASE_BOUNCE: 0 for the first BOUNCE_PERIOD cycles, then 1, alternating every BOUNCE_PERIOD cycles.
- Row output is combinational from col: fila = (pressed && col[c]) ? (4'b0001 << r) : 4'b0000, with c and r taken from code_q.
  - Only bit c of col is examined; other col bits are don't-care.
  - col = 0 gives fila = 0.
- abort: when sampled high in PRESS_BOUNCE or HOLD, the next state is RELEASE_BOUNCE (GAP if BOUNCE_CYCLES = 0, IDLE if GAP_CYCLES is also 0). The bounce phase restarts open. abort is ignored in every other state.
- key_valid outside IDLE is ignored. The command is neither queued nor latched.
- done = 1 for exactly the one cycle after the transition into IDLE, i.e. the first cycle key_ready is 1 again. done also fires after an aborted command.
- A single cycle counter (32-bit) is reloaded on every state change. Each state occupies exactly its parameter count of cycles; no off-by-one.

## Timing
- Reset (rst_n = 0, asynchronous): state IDLE, pressed = 0, fila = 0, key_ready = 1, done = 0, code_q = 0, counters = 0.
- Reset during a press opens the contact immediately, with no release bounce and no done pulse.
- Accept edge E0: pressed reflects the new state from E0 onward.
- Total accept-to-ready latency is 2·BOUNCE_CYCLES + HOLD_CYCLES + GAP_CYCLES cycles. A new accept is possible on the edge where key_ready is first sampled 1.
- fila responds to col with zero cycles of latency, so the scanner samples fila together with its own registered col.

## Test plan
- Params HOLD=8, BOUNCE=0, GAP=3; accept code 4'h6, hold col=4'b0010 -> fila=4'b0100 for 8 cycles, then 0; key_ready returns 11 cycles after accept; done pulses once.
- Same params and code 4'h6; sweep col over 0001, 0100, 1000, 0000 during HOLD -> fila=0 every time; col=4'b0110 -> fila=4'b0100.
- HOLD=8, BOUNCE=4, PERIOD=2, GAP=3; accept code 4'hF with col=4'b1000 -> pressed sequence 1,1,0,0, then 1×8, then 0,0,1,1, then 0×3; fila[3] mirrors pressed; ready after 19 cycles.
- During HOLD: key_valid with code 4'h0 -> ignored, code_q unchanged. Assert abort on HOLD cycle 3 -> RELEASE_BOUNCE next, done one cycle after GAP ends.
- Deassert rst_n asynchronously mid-HOLD -> fila=0 and key_ready=1 before the next clk edge; no done pulse.
- Drive the emulator into the keypad scanner with codes 0..15 in turn -> the scanner reports position equal to each key_code, and its press flag is asserted while pressed = 1.
